// File: rtl/breadboard_lut_seq.sv
// -----------------------------------------------------------------------------
// breadboard_lut_seq
//
// Run-time loadable truth table (2^IN_W entries of OUT_W bits) with a
// registered single-vector evaluate path and a sweep engine that streams
// every table entry, one per cycle, in index order.
//
// Optional feature macro: BREADBOARD_SIGNATURE_EN
//   When defined, adds output sig: a rotate-left/XOR signature of the
//   sweep result stream, cleared at the start of each sweep.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   cfg_we       table write strobe (honoured only when idle)
//   cfg_addr     table write address
//   cfg_data     table write data
//   in_valid     evaluate request (honoured only when idle)
//   in_vec       input vector to evaluate
//   in_ready     high when evaluate requests are accepted (= !sweep_busy)
//   sweep_start  start-sweep pulse (ignored while sweeping)
//   sweep_busy   sweep engine active
//   sweep_done   one-cycle pulse alongside the last sweep result
//   out_valid    result valid
//   out_vec      table[out_idx]
//   out_idx      input vector that produced out_vec
//   sig          sweep signature (only with BREADBOARD_SIGNATURE_EN)
// -----------------------------------------------------------------------------
module breadboard_lut_seq #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [IN_W-1:0]  cfg_addr,
    input  logic [OUT_W-1:0] cfg_data,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_vec,
    output logic             in_ready,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             sweep_done,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_vec,
    output logic [IN_W-1:0]  out_idx
`ifdef BREADBOARD_SIGNATURE_EN
    ,
    output logic [OUT_W-1:0] sig
`endif
);

    localparam int DEPTH = 1 << IN_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t state, state_next;

    // The table must clear on reset, so it is built from flops rather
    // than block RAM.
    logic [OUT_W-1:0] lut_mem [DEPTH];
    logic [IN_W-1:0]  cnt;
    logic             last_idx;

    assign last_idx   = (cnt == {IN_W{1'b1}});
    assign sweep_busy = (state == SWEEP);
    assign in_ready   = (state == IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sweep_start) state_next = SWEEP;
            SWEEP:   if (last_idx)    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Table storage: writes only while idle. Reads elsewhere see the
    // pre-write contents, giving read-old-data on a same-address collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                lut_mem[i] <= '0;
            end
        end else if (state == IDLE && cfg_we) begin
            lut_mem[cfg_addr] <= cfg_data;
        end
    end

    // Result path and sweep counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_vec    <= '0;
            out_idx    <= '0;
            sweep_done <= 1'b0;
            cnt        <= '0;
        end else begin
            out_valid  <= 1'b0;
            sweep_done <= 1'b0;
            if (state == SWEEP) begin
                out_valid <= 1'b1;
                out_vec   <= lut_mem[cnt];
                out_idx   <= cnt;
                if (last_idx) begin
                    // Stop after the all-ones index; no second pass.
                    sweep_done <= 1'b1;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (in_valid) begin
                out_valid <= 1'b1;
                out_vec   <= lut_mem[in_vec];
                out_idx   <= in_vec;
            end
        end
    end

`ifdef BREADBOARD_SIGNATURE_EN
    // Signature folds each sweep result in as it is registered; evaluate
    // results never touch it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (state == IDLE && sweep_start) begin
            sig <= '0;
        end else if (state == SWEEP) begin
            sig <= {sig[OUT_W-2:0], sig[OUT_W-1]} ^ lut_mem[cnt];
        end
    end
`endif

endmodule

// File: tb/tb_breadboard_lut_seq.sv
module tb_breadboard_lut_seq;

    localparam int IN_W  = 4;
    localparam int OUT_W = 10;
    localparam int DEPTH = 1 << IN_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cfg_we = 1'b0;
    logic [IN_W-1:0]  cfg_addr = '0;
    logic [OUT_W-1:0] cfg_data = '0;
    logic             in_valid = 1'b0;
    logic [IN_W-1:0]  in_vec = '0;
    logic             in_ready;
    logic             sweep_start = 1'b0;
    logic             sweep_busy;
    logic             sweep_done;
    logic             out_valid;
    logic [OUT_W-1:0] out_vec;
    logic [IN_W-1:0]  out_idx;
`ifdef BREADBOARD_SIGNATURE_EN
    logic [OUT_W-1:0] sig;
`endif

    breadboard_lut_seq #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .in_valid    (in_valid),
        .in_vec      (in_vec),
        .in_ready    (in_ready),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .sweep_done  (sweep_done),
        .out_valid   (out_valid),
        .out_vec     (out_vec),
        .out_idx     (out_idx)
`ifdef BREADBOARD_SIGNATURE_EN
        ,
        .sig         (sig)
`endif
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [OUT_W-1:0] m_tbl [DEPTH];
    bit               m_busy;
    int               m_pos;
    bit               m_valid, m_done;
    logic [OUT_W-1:0] m_vec;
    logic [IN_W-1:0]  m_idx;
    logic [OUT_W-1:0] m_sig;

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = '0;
        m_busy = 0; m_pos = 0; m_valid = 0; m_done = 0;
        m_vec = '0; m_idx = '0; m_sig = '0;
    endtask

    // Apply one clock's worth of inputs to the model.
    task automatic model_step(input bit we, input int addr, input int data,
                              input bit iv, input int vec, input bit ss);
        m_valid = 0;
        m_done  = 0;
        if (m_busy) begin
            m_valid = 1;
            m_vec   = m_tbl[m_pos];
            m_idx   = m_pos[IN_W-1:0];
            m_sig   = {m_sig[OUT_W-2:0], m_sig[OUT_W-1]} ^ m_vec;
            if (m_pos == DEPTH - 1) begin
                m_done = 1;
                m_busy = 0;
            end
            m_pos++;
        end else begin
            if (iv) begin
                m_valid = 1;
                m_vec   = m_tbl[vec];
                m_idx   = vec[IN_W-1:0];
            end
            if (we) m_tbl[addr] = data[OUT_W-1:0];
            if (ss) begin
                m_busy = 1;
                m_pos  = 0;
                m_sig  = '0;
            end
        end
    endtask

    // Drive one cycle, step the model, check all outputs 1 time unit after the edge.
    task automatic do_cycle(input bit we, input int addr, input int data,
                            input bit iv, input int vec, input bit ss);
        cfg_we      = we;
        cfg_addr    = addr[IN_W-1:0];
        cfg_data    = data[OUT_W-1:0];
        in_valid    = iv;
        in_vec      = vec[IN_W-1:0];
        sweep_start = ss;
        model_step(we, addr, data, iv, vec, ss);
        @(posedge clk);
        #1;
        cfg_we = 0; in_valid = 0; sweep_start = 0;
        check("out_valid",  out_valid,  m_valid);
        check("out_vec",    out_vec,    m_vec);
        check("out_idx",    out_idx,    m_idx);
        check("sweep_done", sweep_done, m_done);
        check("sweep_busy", sweep_busy, m_busy);
        check("in_ready",   in_ready,   !m_busy);
        if (out_valid)
            $display("[TB] t=%0t idx=%0d vec=0x%03h done=%0b busy=%0b", $time, out_idx, out_vec, sweep_done, sweep_busy);
    endtask

    task automatic idle_cycle();
        do_cycle(0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid,  0);
        check({tag, "_vec"},   out_vec,    0);
        check({tag, "_idx"},   out_idx,    0);
        check({tag, "_busy"},  sweep_busy, 0);
        check({tag, "_done"},  sweep_done, 0);
        check({tag, "_ready"}, in_ready,   1);
    endtask

    int busy_cnt, done_cnt, done_idx, guard;

    initial begin
        model_reset();
        // ---- reset ----
        #2 rst = 1;
        #1 check_reset_outputs("rst");
        @(posedge clk); #1 check_reset_outputs("rst_hold");
        @(negedge clk) rst = 0;
        @(posedge clk); #1;

        // ---- reset then evaluate 5 ----
        do_cycle(0, 0, 0, 1, 5, 0);
        // ---- write then evaluate ----
        do_cycle(1, 3, 'h3FF, 0, 0, 0);
        do_cycle(0, 0, 0, 1, 3, 0);
        check("eval3_vec", out_vec, 'h3FF);
        do_cycle(1, 4, 'h155, 1, 4, 0);
        check("wr_eval_old", out_vec, 'h000);
        do_cycle(0, 0, 0, 1, 4, 0);
        check("reeval_new", out_vec, 'h155);

        // ---- full sweep ----
        for (int k = 0; k < DEPTH; k++) do_cycle(1, k, (k * 'h41) & 'h3FF, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 1);
        busy_cnt = 0; done_cnt = 0; done_idx = -1;
        if (sweep_busy) busy_cnt++;
        for (int c = 0; c < DEPTH + 3; c++) begin
            idle_cycle();
            if (sweep_busy) busy_cnt++;
            if (sweep_done) begin done_cnt++; done_idx = out_idx; end
            if (out_valid) check("sweep_data", out_vec, (out_idx * 'h41) & 'h3FF);
        end
        check("busy_cycles", busy_cnt, DEPTH);
        check("done_count", done_cnt, 1);
        check("done_idx", done_idx, DEPTH - 1);

        // ---- collision and blocking ----
        do_cycle(0, 0, 0, 1, 2, 1);
        check("coll_idx2", out_idx, 2);
        for (int c = 0; c < DEPTH; c++) begin
            if (c == 4) do_cycle(1, 0, 'h2AA, 1, 9, 0);
            else        idle_cycle();
        end
        do_cycle(0, 0, 0, 1, 0, 0);
        check("blocked_write", out_vec, 'h000);

        // ---- randomized traffic ----
        for (int c = 0; c < 400; c++) begin
            do_cycle(($urandom % 4) == 0, $urandom_range(0, DEPTH - 1), $urandom_range(0, (1 << OUT_W) - 1),
                     $urandom % 2, $urandom_range(0, DEPTH - 1), ($urandom % 25) == 0);
        end
        while (m_busy) idle_cycle();

        // ---- reset mid-sweep ----
        do_cycle(0, 0, 0, 0, 0, 1);
        guard = 0;
        while (!(out_valid && out_idx == 7) && guard < 40) begin
            idle_cycle();
            guard++;
        end
        check("reach_idx7", guard < 40, 1);
        #2 rst = 1;
        #1 check_reset_outputs("midrst");
        model_reset();
        @(negedge clk) rst = 0;
        @(posedge clk); #1;
        for (int c = 0; c < 4; c++) begin
            do_cycle(0, 0, 0, 1, $urandom_range(0, DEPTH - 1), 0);
            check("post_rst_zero", out_vec, 0);
        end

`ifdef BREADBOARD_SIGNATURE_EN
        // ---- signature ----
        for (int k = 0; k < DEPTH; k++) do_cycle(1, k, 1, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 1);
        check("sig_cleared", sig, 0);
        guard = 0;
        while (!sweep_done && guard < 40) begin
            idle_cycle();
            guard++;
        end
        check("sig_done_seen", sweep_done, 1);
        check("sig_final", sig, 'h3C0);
        check("sig_model", sig, m_sig);
        do_cycle(0, 0, 0, 1, 3, 0);
        check("sig_hold", sig, 'h3C0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
